cp0_regfile: RTL and testbench

Coprocessor-0 register file and exception controller for the 5-stage MIPS pipeline. It consumes the exception, ERET and MTC0 requests issued by the write-back stage, updates the CP0 state, and serves MFC0 reads. It returns flush/redirect information to the front end and an interrupt-pending flag to decode.

---
 rtl/cp0_regfile.sv | 115 +++++++++++
 tb/tb_cp0_regfile.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// cp0_regfile: MIPS CP0 register file and exception controller.
// Optional Count/Compare timer is built only when CP0_TIMER_EN is defined.
module cp0_regfile #(
    parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_excp,
    input  logic [4:0]  wb_excode,
    input  logic        wb_bd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badvaddr,
    input  logic        wb_eret,
    input  logic        wb_mtc0,
    input  logic [7:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    input  logic [7:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic [5:0]  ext_int_in,
    output logic        excp_flush,
    output logic [31:0] excp_pc,
    output logic        eret_flush,
    output logic [31:0] epc_out,
    output logic        has_int
);
    localparam logic [7:0] A_BADV   = 8'h40;
    localparam logic [7:0] A_COUNT  = 8'h48;
    localparam logic [7:0] A_CMP    = 8'h58;
    localparam logic [7:0] A_STATUS = 8'h60;
    localparam logic [7:0] A_CAUSE  = 8'h68;
    localparam logic [7:0] A_EPC    = 8'h70;

    logic [31:0] badvaddr, epc, count, compare, status_rd, cause_rd;
    logic [7:0]  im;
    logic        exl, ie, bd, ti;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic [4:0]  excode;
    logic        excp, eret, mtc0;

    assign excp       = wb_valid && wb_excp;
    assign eret       = wb_valid && wb_eret && !wb_excp;
    assign mtc0       = wb_valid && wb_mtc0 && !wb_excp;
    assign excp_flush = excp;
    assign eret_flush = eret;
    assign excp_pc    = EXC_ENTRY;
    assign epc_out    = epc;

    // Later statements win, giving exception > ERET > MTC0 > hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            badvaddr <= '0;
            epc      <= '0;
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            excode   <= '0;
        end else begin
            ip_hw <= {ext_int_in[5] | ti, ext_int_in[4:0]};
            if (mtc0 && wb_addr == A_STATUS) begin
                im  <= wb_wdata[15:8];
                exl <= wb_wdata[1];
                ie  <= wb_wdata[0];
            end
            if (mtc0 && wb_addr == A_CAUSE) ip_sw <= wb_wdata[9:8];
            if (mtc0 && wb_addr == A_EPC) epc <= wb_wdata;
            if (eret) exl <= 1'b0;
            if (excp) begin
                if (!exl) begin
                    epc <= wb_bd ? wb_pc - 32'd4 : wb_pc;
                    bd  <= wb_bd;
                end
                exl    <= 1'b1;
                excode <= wb_excode;
                if (wb_excode == 5'h04 || wb_excode == 5'h05) badvaddr <= wb_badvaddr;
            end
        end
    end

`ifdef CP0_TIMER_EN
    logic tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick    <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            tick  <= ~tick;
            count <= (mtc0 && wb_addr == A_COUNT) ? wb_wdata : count + {31'd0, tick};
            if (mtc0 && wb_addr == A_CMP) compare <= wb_wdata;
            ti    <= (mtc0 && wb_addr == A_CMP) ? 1'b0 : (ti | (count == compare));
        end
    end
`else
    assign count   = '0;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

    assign status_rd = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    assign cause_rd  = {bd, ti, 14'd0, ip_hw, ip_sw, 1'b0, excode, 2'b00};
    assign rd_data   = rd_addr == A_BADV   ? badvaddr  :
                       rd_addr == A_COUNT  ? count     :
                       rd_addr == A_CMP    ? compare   :
                       rd_addr == A_STATUS ? status_rd :
                       rd_addr == A_CAUSE  ? cause_rd  :
                       rd_addr == A_EPC    ? epc       : 32'd0;
    assign has_int   = (|({ip_hw, ip_sw} & im)) && ie && !exl;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: scoreboard bench for cp0_regfile against a word-level CP0 model.
// Timer expectations follow CP0_TIMER_EN the same way the design does.
module tb_cp0_regfile;
    localparam logic [31:0] EXC = 32'hBFC0_0380;
`ifdef CP0_TIMER_EN
    localparam logic [31:0] TIB = 32'h4000_8000;
`else
    localparam logic [31:0] TIB = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        reset, wb_valid, wb_excp, wb_bd, wb_eret, wb_mtc0;
    logic [4:0]  wb_excode;
    logic [31:0] wb_pc, wb_badvaddr, wb_wdata, rd_data, excp_pc, epc_out;
    logic [7:0]  wb_addr, rd_addr;
    logic [5:0]  ext_int_in;
    logic        excp_flush, eret_flush, has_int;

    always #5 clk = ~clk;

    cp0_regfile dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_excp(wb_excp),
        .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
        .wb_eret(wb_eret), .wb_mtc0(wb_mtc0), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data), .ext_int_in(ext_int_in),
        .excp_flush(excp_flush), .excp_pc(excp_pc), .eret_flush(eret_flush),
        .epc_out(epc_out), .has_int(has_int)
    );

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        ef;
        logic        rf;
        logic [31:0] epc;
        logic        hi;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Architectural state held as whole register words.
    logic [31:0] m_status = 32'h0040_0000, m_cause = 0, m_epc = 0, m_bad = 0, m_count = 0, m_cmp = 0;
    logic        m_tick = 1'b0;

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h40: return m_bad;
            8'h48: return m_count;
            8'h58: return m_cmp;
            8'h60: return m_status;
            8'h68: return m_cause;
            8'h70: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic push(input string tag, input bit use_k, input logic [31:0] k);
        exp_t e;
        e.tag = tag;
        e.rd  = use_k ? k : m_read(rd_addr);
        e.ef  = wb_valid && wb_excp;
        e.rf  = wb_valid && wb_eret && !wb_excp;
        e.epc = m_epc;
        e.hi  = (|(m_cause[15:8] & m_status[15:8])) && m_status[0] && !m_status[1];
        q.push_back(e);
    endtask

    task automatic model_step();
        logic [31:0] s, c, e, b, cnt, cmp;
        logic        tk;
        s = m_status; c = m_cause; e = m_epc; b = m_bad; cnt = m_count; cmp = m_cmp; tk = m_tick;
        if (reset) begin
            s = 32'h0040_0000; c = 0; e = 0; b = 0; cnt = 0; cmp = 0; tk = 1'b0;
        end else begin
            c[15:10] = {ext_int_in[5] | m_cause[30], ext_int_in[4:0]};
`ifdef CP0_TIMER_EN
            tk = ~m_tick;
            if (m_tick) cnt = m_count + 1;
            if (m_count == m_cmp) c[30] = 1'b1;
`endif
            if (wb_valid && wb_mtc0 && !wb_excp) begin
                case (wb_addr)
                    8'h60: s = (s & ~32'h0000_FF03) | (wb_wdata & 32'h0000_FF03);
                    8'h68: c = (c & ~32'h0000_0300) | (wb_wdata & 32'h0000_0300);
                    8'h70: e = wb_wdata;
`ifdef CP0_TIMER_EN
                    8'h48: cnt = wb_wdata;
                    8'h58: begin cmp = wb_wdata; c[30] = 1'b0; end
`endif
                    default: ;
                endcase
            end
            if (wb_valid && wb_eret && !wb_excp) s[1] = 1'b0;
            if (wb_valid && wb_excp) begin
                if (!m_status[1]) begin
                    e = wb_bd ? wb_pc - 32'd4 : wb_pc;
                    c[31] = wb_bd;
                end
                s[1] = 1'b1;
                c[6:2] = wb_excode;
                if (wb_excode == 5'h04 || wb_excode == 5'h05) b = wb_badvaddr;
            end
        end
        m_status = s; m_cause = c; m_epc = e; m_bad = b; m_count = cnt; m_cmp = cmp; m_tick = tk;
    endtask

    task automatic step(input string tag, input bit use_k = 1'b0, input logic [31:0] k = 32'h0);
        push(tag, use_k, k);
        @(posedge clk);
        model_step();
        #1;
        reset = 1'b0; wb_valid = 1'b0; wb_excp = 1'b0; wb_eret = 1'b0; wb_mtc0 = 1'b0; wb_bd = 1'b0;
    endtask

    task automatic mtc0(input string tag, input logic [7:0] a, input logic [31:0] d);
        wb_valid = 1'b1; wb_mtc0 = 1'b1; wb_addr = a; wb_wdata = d;
        step(tag);
    endtask

    task automatic chk(input string tag, input string f, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s %s got=%h want=%h", tag, f, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, "rd_data", rd_data, e.rd);
            chk(e.tag, "excp_flush", {31'd0, excp_flush}, {31'd0, e.ef});
            chk(e.tag, "eret_flush", {31'd0, eret_flush}, {31'd0, e.rf});
            chk(e.tag, "epc_out", epc_out, e.epc);
            chk(e.tag, "has_int", {31'd0, has_int}, {31'd0, e.hi});
            chk(e.tag, "excp_pc", excp_pc, EXC);
        end
    end

    localparam logic [7:0] ADDRS [7] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h00};

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_excp = 1'b0; wb_eret = 1'b0; wb_mtc0 = 1'b0; wb_bd = 1'b0;
        wb_excode = '0; wb_pc = '0; wb_badvaddr = '0; wb_addr = '0; wb_wdata = '0;
        rd_addr = 8'h68; ext_int_in = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step("rst_cause", 1, 32'h0);
        rd_addr = 8'h48; step("rst_count", 1, 32'h0);
        rd_addr = 8'h40; step("rst_badv", 1, 32'h0);
        rd_addr = 8'h60; step("rst_status", 1, 32'h0040_0000);
        rd_addr = 8'h70; step("rst_epc", 1, 32'h0);
        wb_valid = 1'b1; wb_excp = 1'b1; wb_excode = 5'h08; wb_pc = 32'hBFC0_0100;
        step("exc1");
        step("exc1_epc", 1, 32'hBFC0_0100);
        rd_addr = 8'h68; step("exc1_cause", 1, 32'h0000_0020 | TIB);
        rd_addr = 8'h60; step("exc1_status", 1, 32'h0040_0002);
        wb_valid = 1'b1; wb_eret = 1'b1;
        step("eret1");
        step("eret1_status", 1, 32'h0040_0000);
        wb_valid = 1'b1; wb_excp = 1'b1; wb_bd = 1'b1; wb_excode = 5'h04;
        wb_pc = 32'hBFC0_0204; wb_badvaddr = 32'h0000_0003;
        step("exc_bd");
        rd_addr = 8'h70; step("exc_bd_epc", 1, 32'hBFC0_0200);
        rd_addr = 8'h68; step("exc_bd_cause", 1, 32'h8000_0010 | TIB);
        rd_addr = 8'h40; step("exc_bd_badv", 1, 32'h0000_0003);
        wb_valid = 1'b1; wb_excp = 1'b1; wb_excode = 5'h08; wb_pc = 32'h0000_1234;
        step("exc_nest");
        rd_addr = 8'h70; step("nest_epc", 1, 32'hBFC0_0200);
        rd_addr = 8'h68; step("nest_cause", 1, 32'h8000_0020 | TIB);
        rd_addr = 8'h40; step("nest_badv", 1, 32'h0000_0003);
        wb_valid = 1'b1; wb_excp = 1'b1; wb_eret = 1'b1; wb_excode = 5'h08;
        step("eret_excp");
        rd_addr = 8'h60;
        mtc0("mtc0_status", 8'h60, 32'hFFFF_FFFF);
        step("mask_status", 1, 32'h0040_FF03);
        rd_addr = 8'h68;
        mtc0("mtc0_cause", 8'h68, 32'hFFFF_FFFF);
        step("mask_cause", 1, 32'h8000_0320 | TIB);
        rd_addr = 8'h40;
        mtc0("mtc0_badv", 8'h40, 32'hDEAD_BEEF);
        step("mask_badv", 1, 32'h0000_0003);
        wb_valid = 1'b1; wb_eret = 1'b1;
        step("eret2");
        step("int_sw");
        mtc0("clr_cause", 8'h68, 32'h0);
        mtc0("clr_status", 8'h60, 32'h0);
`ifdef CP0_TIMER_EN
        rd_addr = 8'h68;
        mtc0("count0", 8'h48, 32'h0);
        mtc0("cmp5", 8'h58, 32'h5);
        mtc0("status_im7", 8'h60, 32'h0000_8001);
        repeat (14) step("timer_wait");
        step("timer_ti", 1, 32'hC000_8020);
        mtc0("cmp100", 8'h58, 32'd100);
        step("ti_clear");
        step("ti_cleared", 1, 32'h8000_0020);
`endif
        for (int i = 0; i < 3000; i++) begin
            int k;
            k = int'($urandom % 8);
            reset       = ($urandom % 256) == 0;
            wb_valid    = ($urandom % 4) != 0;
            wb_excp     = k == 0;
            wb_eret     = k == 1 || (k == 0 && $urandom % 2 == 1);
            wb_mtc0     = (k >= 2 && k <= 4) || (k == 0 && $urandom % 2 == 1);
            wb_addr     = ADDRS[$urandom % 7];
            if (wb_addr == 8'h00) wb_addr = 8'($urandom);
            wb_wdata    = ($urandom % 2 == 1) ? $urandom : $urandom % 16;
            wb_excode   = ($urandom % 2 == 1) ? 5'(4 + $urandom % 2) : 5'($urandom);
            wb_bd       = $urandom % 2 == 1;
            wb_pc       = $urandom;
            wb_badvaddr = $urandom;
            ext_int_in  = ($urandom % 4 == 0) ? 6'($urandom) : 6'd0;
            rd_addr     = ADDRS[$urandom % 7];
            step("rand");
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
